// File: rtl/dt_integrator_if.sv
// Stream bundle for the dT integrator: measured-T and dT sample inputs, reconstructed-T output.
// The master drives the samples; the slave (the integrator) returns T_rec/T_valid.
interface dt_integrator_if;
  logic [7:0] T_meas;
  logic       meas_valid;
  logic [7:0] dT_in;
  logic       dT_valid;
  logic [7:0] T_rec;
  logic       T_valid;

  modport master (
    output T_meas, meas_valid, dT_in, dT_valid,
    input  T_rec, T_valid
  );

  modport slave (
    input  T_meas, meas_valid, dT_in, dT_valid,
    output T_rec, T_valid
  );
endinterface

// File: rtl/dt_integrator.sv
// Reconstructs temperature by saturating accumulation of scaled dT samples, with a sticky drift check.
// Latency 1 cycle from accepted sample to T_rec/T_valid; no backpressure, every valid sample is consumed.
module dt_integrator #(
  parameter int W_ACC = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               init,
  input  logic [7:0]         K_DT,
  input  logic [7:0]         TOL,
  input  logic [3:0]         N_FAULT,
  output logic               drift_flag,
  output logic [1:0]         state,
  dt_integrator_if.slave     io
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_TRACK = 2'b01,
    ST_FAULT = 2'b10
  } state_t;

  localparam logic signed [W_ACC:0]   SUM_HI = 127;
  localparam logic signed [W_ACC:0]   SUM_LO = -128;
  localparam logic signed [W_ACC-1:0] ACC_HI = 127;
  localparam logic signed [W_ACC-1:0] ACC_LO = -128;

  state_t                   state_q, state_d;
  logic signed [W_ACC-1:0]  acc_q, acc_d;
  logic [3:0]               viol_q, viol_d;
  logic                     t_valid_q, t_valid_d;
  logic                     drift_q, drift_d;

  logic [2:0]               shamt;
  logic signed [W_ACC-1:0]  dt_ext;
  logic signed [W_ACC-1:0]  step;
  logic signed [W_ACC:0]    sum;
  logic signed [W_ACC-1:0]  acc_sat;
  logic signed [W_ACC-1:0]  meas_ext;
  logic signed [8:0]        err;
  logic [8:0]               err_abs;
  logic                     out_of_tol;
  logic [3:0]               viol_inc;
  logic [3:0]               n_fault_eff;

  // Datapath: the shifted step can exceed int8 by far, so the add is done one bit wider than acc.
  always_comb begin
    shamt       = (K_DT > 8'd7) ? 3'd7 : K_DT[2:0];
    dt_ext      = W_ACC'($signed(io.dT_in));
    step        = dt_ext <<< shamt;
    sum         = $signed({acc_q[W_ACC-1], acc_q}) + $signed({step[W_ACC-1], step});
    if (sum > SUM_HI)
      acc_sat = ACC_HI;
    else if (sum < SUM_LO)
      acc_sat = ACC_LO;
    else
      acc_sat = sum[W_ACC-1:0];

    meas_ext    = W_ACC'($signed(io.T_meas));
    err         = $signed({io.T_meas[7], io.T_meas}) - $signed({acc_q[7], acc_q[7:0]});
    err_abs     = err[8] ? 9'(-err) : 9'(err);
    out_of_tol  = err_abs > {1'b0, TOL};
    viol_inc    = (viol_q == 4'hF) ? 4'hF : viol_q + 4'd1;
    n_fault_eff = (N_FAULT == 4'd0) ? 4'd1 : N_FAULT;
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    viol_d    = viol_q;
    t_valid_d = 1'b0;
    drift_d   = drift_q;

    if (init) begin
      state_d = ST_IDLE;
      acc_d   = '0;
      viol_d  = '0;
      drift_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (io.meas_valid) begin
            acc_d     = meas_ext;
            t_valid_d = 1'b1;
            state_d   = ST_TRACK;
          end
        end
        ST_TRACK: begin
          // The drift check sees the pre-update T_rec even when a dT lands on the same edge.
          if (io.meas_valid) begin
            if (out_of_tol) begin
              viol_d = viol_inc;
              if (viol_inc >= n_fault_eff) begin
                state_d = ST_FAULT;
                drift_d = 1'b1;
              end
            end else begin
              viol_d = '0;
            end
          end
          if (io.dT_valid) begin
            acc_d     = acc_sat;
            t_valid_d = 1'b1;
          end
        end
        ST_FAULT: begin
          if (io.meas_valid) begin
            acc_d     = meas_ext;
            t_valid_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          acc_d   = '0;
          viol_d  = '0;
          drift_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      viol_q    <= '0;
      t_valid_q <= 1'b0;
      drift_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      viol_q    <= viol_d;
      t_valid_q <= t_valid_d;
      drift_q   <= drift_d;
    end
  end

  assign io.T_rec    = acc_q[7:0];
  assign io.T_valid  = t_valid_q;
  assign drift_flag  = drift_q;
  assign state       = state_q;

endmodule

// File: doc/dt_integrator.md
Name: dt_integrator

Overview:
- Inverse of the dT estimation path. Accepts a stream of Q7.0 dT samples and reconstructs the temperature trajectory by scaled accumulation: T_rec += dT << K_DT.
- Periodically compares the reconstruction against measured T and raises a sticky drift fault after N consecutive out-of-tolerance checks.
- Sits downstream of the dT estimator output. Used for consistency checking and for hold-over when measurements are sparse.

Parameters:
- W_ACC, 16, internal signed accumulator width (must be >= 16).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- init  in  1  CTRL.INIT; synchronous, forces IDLE and clears all state
- T_meas  in  8  signed Q7.0 measured temperature
- meas_valid  in  1  T_meas is valid this cycle
- dT_in  in  8  signed Q7.0 temperature-difference sample
- dT_valid  in  1  dT_in is valid this cycle
- K_DT  in  8  unsigned scale exponent; values above 7 are treated as 7
- TOL  in  8  unsigned drift tolerance, in LSB
- N_FAULT  in  4  consecutive violations required to fault; 0 is treated as 1
- T_rec  out  8  signed Q7.0 reconstructed temperature
- T_valid  out  1  one-cycle pulse when T_rec has been updated
- drift_flag  out  1  sticky fault indicator
- state  out  2  00 IDLE, 01 TRACK, 10 FAULT

Behaviour:
- Reset (rst_n=0, async):
  - Outputs: T_rec=0, T_valid=0, drift_flag=0, state=IDLE.
  - Internal: acc=0, viol_cnt=0.
- init=1 on a clock edge: same values as reset, applied synchronously. init takes priority over all other inputs.
- IDLE:
  - dT_valid is ignored.
  - On meas_valid: acc <= sext(T_meas), T_rec <= T_meas, T_valid pulses next cycle, go to TRACK.
- TRACK, integration:
  - On dT_valid: step = sext(dT_in, W_ACC) <<< min(K_DT,7).
  - acc <= sat8(acc + step), where sat8 clamps to [-128,127] on every add.
  - T_rec <= new acc[7:0]. T_valid=1 in the following cycle. Latency is 1 cycle.
- TRACK, drift check on meas_valid:
  - err = T_meas - T_rec, computed at 9 bits signed using the pre-update T_rec.
  - If |err| > TOL: viol_cnt++, saturating at 15. Otherwise viol_cnt <= 0.
  - When viol_cnt would reach max(N_FAULT,1): go to FAULT and set drift_flag=1 on the same edge.
- TRACK, dT_valid and meas_valid in the same cycle: the check uses the old T_rec and the integration proceeds normally. Both actions occur on that edge.
- FAULT:
  - dT_valid is ignored.
  - On meas_valid: acc <= sext(T_meas), T_rec <= T_meas, T_valid pulses (pass-through).
  - drift_flag stays at 1 and the block stays in FAULT until init or reset.
- T_valid:
  - Never high for more than one cycle per accepted sample.
  - Low in every cycle in which no update occurred.
- Saturation: acc is held within int8 range at all times. Wrap-around is prohibited.
- Reset asserted mid-operation: immediate return to reset values, with no pending T_valid.

Test Plan:
- Seed and ramp: reset, then meas_valid with T_meas=10 → T_rec=10, state=TRACK. Then 5× dT_valid with dT_in=2, K_DT=1 → T_rec=14,18,22,26,30, each with a 1-cycle T_valid pulse.
- Positive saturation: T_rec=100, dT_in=+20, K_DT=2 → T_rec=127 (no wrap). A further dT_in=-1, K_DT=0 → T_rec=126.
- Scale clamp: K_DT=200, dT_in=1 from T_rec=0 → T_rec=127 (shift of 7 saturates). dT_in=-1 from T_rec=0 → T_rec=-128.
- Drift fault: TOL=3, N_FAULT=2, T_rec=20.
  - meas T=25 → viol_cnt=1. meas T=19 → viol_cnt=0. meas T=30 → viol_cnt=1. meas T=30 → state=FAULT, drift_flag=1.
  - Afterwards, dT_valid is ignored and meas T=40 → T_rec=40.
- Simultaneous events: T_rec=20, TOL=0, N_FAULT=1, meas T=20 with dT_valid dT=5, K_DT=0 in the same cycle → no fault, T_rec=25.
- Init and async reset: in FAULT, pulse init → state=IDLE, drift_flag=0, and a dT_valid in IDLE leaves T_rec=0. Drop rst_n mid-ramp → outputs return to zero immediately without waiting for a clock edge.
